// File: rtl/pkt_rr_scheduler.sv
`default_nettype none
// ============================================================================
// pkt_rr_scheduler : packet-granular round-robin merge of NUM_REQ beat streams
// Rev 1.0
// ============================================================================
module pkt_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int PLEN_WIDTH = 14,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_sop,
  input  logic [NUM_REQ-1:0]            req_eop,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*PLEN_WIDTH-1:0] req_plen,
  input  logic [NUM_REQ-1:0]            req_bad,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [PLEN_WIDTH-1:0]         out_plen,
  input  logic                          out_ready,
  output logic [CNT_WIDTH-1:0]          fwd_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic                          err_proto
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_FWD  = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [PLEN_WIDTH-1:0] plen_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign plen_arr[gi] = req_plen[gi*PLEN_WIDTH +: PLEN_WIDTH];
  end

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [PLEN_WIDTH-1:0] plen_q, plen_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [PLEN_WIDTH-1:0] out_plen_q, out_plen_d;
  logic [CNT_WIDTH-1:0]  fwd_cnt_q, fwd_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic                  err_proto_q, err_proto_d;

  logic [GW-1:0] pick;
  logic [GW-1:0] scan_idx;
  logic          pick_vld;
  logic          load_en;
  logic          head_valid;
  logic          head_sop;
  logic          head_eop;
  logic          head_bad;
  logic          accept;

  assign load_en    = ~out_valid_q | out_ready;
  assign head_valid = req_valid[grant_q];
  assign head_sop   = req_sop[grant_q];
  assign head_eop   = req_eop[grant_q];
  assign head_bad   = req_bad[grant_q];
  assign accept     = head_valid & req_ready[grant_q];

  // Descending scan so the nearest valid requester after last_grant wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_FWD) begin
      req_ready[grant_q] = load_en;
    end else if (state_q == S_DROP) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    plen_d       = plen_q;
    out_valid_d  = out_valid_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_data_d   = out_data_q;
    out_plen_d   = out_plen_q;
    fwd_cnt_d    = fwd_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    err_proto_d  = 1'b0;

    // The output stage drains in every state; a new beat overrides below.
    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (head_valid) begin
          last_grant_d = grant_q;
          if (!head_sop) begin
            state_d     = S_DROP;
            err_proto_d = 1'b1;
          end else if (head_bad) begin
            state_d = S_DROP;
          end else begin
            state_d = S_FWD;
            plen_d  = plen_arr[grant_q];
          end
        end
      end
      S_FWD: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_sop_d   = head_sop;
          out_eop_d   = head_eop;
          out_data_d  = data_arr[grant_q];
          out_plen_d  = plen_q;
          if (head_eop) begin
            if (fwd_cnt_q != '1) begin
              fwd_cnt_d = fwd_cnt_q + 1'b1;
            end
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (accept && head_eop) begin
          if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      plen_q       <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_data_q   <= '0;
      out_plen_q   <= '0;
      fwd_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      err_proto_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      plen_q       <= plen_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_data_q   <= out_data_d;
      out_plen_q   <= out_plen_d;
      fwd_cnt_q    <= fwd_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      err_proto_q  <= err_proto_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_data  = out_data_q;
  assign out_plen  = out_plen_q;
  assign fwd_cnt   = fwd_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_proto = err_proto_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_pkt_rr_scheduler : random + directed bench against a packet-level model
// Rev 1.0
// ============================================================================
module tb_pkt_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int PW = 14;
  localparam int CW = 16;
  localparam int SW = 3;
  localparam int MAX_CYC = 5000;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [PW-1:0] plen;
    logic          sop;
    logic          eop;
    logic          bad;
    logic          first;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [PW-1:0] plen;
    logic          sop;
    logic          eop;
  } obeat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_sop, req_eop, req_bad, req_ready, s_req_ready;
  logic [N*DW-1:0] req_data;
  logic [N*PW-1:0] req_plen;
  logic            out_valid, out_sop, out_eop, out_ready, err_proto;
  logic [DW-1:0]   out_data;
  logic [PW-1:0]   out_plen;
  logic [CW-1:0]   fwd_cnt, drop_cnt;
  logic            s_out_valid, s_out_sop, s_out_eop, s_err_proto;
  logic [DW-1:0]   s_out_data;
  logic [PW-1:0]   s_out_plen;
  logic [SW-1:0]   s_fwd_cnt, s_drop_cnt;

  pkt_rr_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .PLEN_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop),
    .req_data(req_data), .req_plen(req_plen), .req_bad(req_bad), .req_ready(req_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_plen(out_plen), .out_ready(out_ready), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt),
    .err_proto(err_proto)
  );

  // Narrow-counter twin sees identical traffic so saturation is reachable quickly.
  pkt_rr_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .PLEN_WIDTH(PW), .CNT_WIDTH(SW)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop),
    .req_data(req_data), .req_plen(req_plen), .req_bad(req_bad), .req_ready(s_req_ready),
    .out_valid(s_out_valid), .out_sop(s_out_sop), .out_eop(s_out_eop), .out_data(s_out_data),
    .out_plen(s_out_plen), .out_ready(out_ready), .fwd_cnt(s_fwd_cnt), .drop_cnt(s_drop_cnt),
    .err_proto(s_err_proto)
  );

  always #5 clk = ~clk;

  beat_t  rq [N][$];
  obeat_t exp_q [$];
  int n_chk = 0;
  int n_pass = 0;
  int m_fwd, m_drop, m_err;
  int cyc, first_rdy0, first_ov, ov_cnt, err_cnt, beats_out;
  int rdy_cnt [N];
  int ready_mode;
  bit bubbles, stall_rdy_chk, prev_stall, last_ov;
  logic [DW-1:0] prev_data;
  logic [PW+2:0] prev_ctl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic gen_pkt(input int r, input int kind, input int nb, input int plen);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.data  = {$urandom, $urandom};
      b.first = (i == 0);
      b.eop   = (i == nb - 1);
      if (i == 0) begin
        b.sop  = (kind != 2);
        b.bad  = (kind == 1);
        b.plen = PW'(plen);
      end else begin
        b.sop  = 1'b0;
        b.bad  = 1'($urandom);
        b.plen = PW'($urandom);
      end
      rq[r].push_back(b);
    end
  endtask

  // Packet-level reference: round-robin over requesters holding packets.
  task automatic build_expected();
    beat_t  cp [N][$];
    beat_t  b, hd;
    obeat_t o;
    int     last, pick;
    bit     done, good;
    for (int r = 0; r < N; r++) cp[r] = rq[r];
    last = N - 1;
    m_fwd = 0; m_drop = 0; m_err = 0;
    exp_q.delete();
    done = 1'b0;
    while (!done) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && cp[(last + k) % N].size() > 0) pick = (last + k) % N;
      if (pick < 0) begin
        done = 1'b1;
      end else begin
        last = pick;
        hd   = cp[pick][0];
        good = hd.sop && !hd.bad;
        b.eop = 1'b0;
        while (!b.eop) begin
          b = cp[pick].pop_front();
          if (good) begin
            o.data = b.data; o.plen = hd.plen; o.sop = b.sop; o.eop = b.eop;
            exp_q.push_back(o);
          end
        end
        if (good) m_fwd++; else m_drop++;
        if (!hd.sop) m_err++;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    beat_t  b;
    obeat_t o;
    @(negedge clk);
    for (int r = 0; r < N; r++) begin
      if (rq[r].size() > 0 && (rq[r][0].first || !bubbles || $urandom_range(0, 3) != 0)) begin
        b = rq[r][0];
        req_valid[r] = 1'b1;
        req_sop[r]   = b.sop;
        req_eop[r]   = b.eop;
        req_bad[r]   = b.bad;
        req_data[r*DW +: DW] = b.data;
        req_plen[r*PW +: PW] = b.plen;
      end else begin
        req_valid[r] = 1'b0;
        req_sop[r]   = 1'($urandom);
        req_eop[r]   = 1'($urandom);
        req_bad[r]   = 1'($urandom);
        req_data[r*DW +: DW] = {$urandom, $urandom};
        req_plen[r*PW +: PW] = PW'($urandom);
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom);
      default: out_ready = !(cyc == 5 || cyc == 6);
    endcase
    #4;
    acc = req_valid & req_ready;
    check("rdy_onehot", 64'($countones(req_ready) <= 1), 64'd1);
    if (stall_rdy_chk && out_valid && !out_ready) check("stall_rdy", 64'(req_ready), 64'd0);
    if (prev_stall) begin
      check("hold_data", out_data, prev_data);
      check("hold_ctl", 64'({out_valid, out_sop, out_eop, out_plen}), 64'(prev_ctl));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_ctl   = {out_valid, out_sop, out_eop, out_plen};
    if (out_valid && out_ready) begin
      beats_out++;
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'(beats_out), 64'd0);
      end else begin
        o = exp_q.pop_front();
        check("beat_data", out_data, o.data);
        check("beat_ctl", 64'({out_sop, out_eop, out_plen}), 64'({o.sop, o.eop, o.plen}));
      end
    end
    if (req_ready[0] && first_rdy0 < 0) first_rdy0 = cyc;
    if (out_valid && first_ov < 0) first_ov = cyc;
    for (int r = 0; r < N; r++) rdy_cnt[r] += int'(req_ready[r]);
    ov_cnt  += int'(out_valid);
    err_cnt += int'(err_proto);
    last_ov  = out_valid;
    @(posedge clk);
    for (int r = 0; r < N; r++) if (acc[r]) rq[r].delete(0);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_sop = '0; req_eop = '0; req_bad = '0;
    req_data = '0; req_plen = '0; out_ready = 1'b1;
    for (int r = 0; r < N; r++) rq[r].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_cnts", 64'({fwd_cnt, drop_cnt, err_proto}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_phase(input int stop_beats);
    bit busy;
    bit pend;
    build_expected();
    cyc = 0; first_rdy0 = -1; first_ov = -1; ov_cnt = 0; err_cnt = 0; beats_out = 0;
    prev_stall = 1'b0; last_ov = 1'b0;
    for (int r = 0; r < N; r++) rdy_cnt[r] = 0;
    busy = 1'b1;
    while (busy) begin
      step();
      pend = 1'b0;
      for (int r = 0; r < N; r++) if (rq[r].size() > 0) pend = 1'b1;
      busy = pend || last_ov || exp_q.size() > 0;
      if (stop_beats > 0 && beats_out >= stop_beats) busy = 1'b0;
      if (cyc >= MAX_CYC) begin
        check("timeout", 64'(cyc), 64'd0);
        busy = 1'b0;
      end
    end
  endtask

  task automatic end_checks();
    @(negedge clk);
    #1;
    check("fwd_cnt", 64'(fwd_cnt), 64'(m_fwd));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("err_pulses", 64'(err_cnt), 64'(m_err));
    check("exp_left", 64'(exp_q.size()), 64'd0);
    check("sat_fwd", 64'(s_fwd_cnt), 64'((m_fwd > 7) ? 7 : m_fwd));
    check("sat_drop", 64'(s_drop_cnt), 64'((m_drop > 7) ? 7 : m_drop));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ready_mode = 0; bubbles = 1'b0; stall_rdy_chk = 1'b0;

    // Single 3-beat packet: latency and length propagation.
    do_reset();
    gen_pkt(0, 0, 3, 20);
    run_phase(0);
    check("first_ready_cyc", 64'(first_rdy0), 64'd2);
    check("first_ov_cyc", 64'(first_ov), 64'd3);
    check("ov_cycles", 64'(ov_cnt), 64'd3);
    end_checks();

    // All four requesters busy with 2-beat packets.
    do_reset();
    for (int p = 0; p < 3; p++) for (int r = 0; r < N; r++) gen_pkt(r, 0, 2, 100 + r);
    run_phase(0);
    end_checks();

    // Bad packet is consumed silently.
    do_reset();
    gen_pkt(2, 1, 4, 33);
    run_phase(0);
    check("bad_ready_cyc", 64'(rdy_cnt[2]), 64'd4);
    check("bad_no_out", 64'(ov_cnt), 64'd0);
    end_checks();

    // Headless packet is a protocol error.
    do_reset();
    gen_pkt(1, 2, 2, 7);
    run_phase(0);
    check("proto_ready_cyc", 64'(rdy_cnt[1]), 64'd2);
    end_checks();

    // Downstream stall mid-packet.
    do_reset();
    ready_mode = 2; stall_rdy_chk = 1'b1;
    gen_pkt(0, 0, 5, 64);
    run_phase(0);
    check("stall_ov_cycles", 64'(ov_cnt), 64'd7);
    end_checks();
    ready_mode = 0; stall_rdy_chk = 1'b0;

    // Asynchronous reset in the middle of a forwarded packet.
    do_reset();
    gen_pkt(0, 0, 1, 9);
    gen_pkt(0, 0, 5, 50);
    run_phase(3);
    #2;
    check("pre_rst_fwd", 64'(fwd_cnt), 64'd1);
    check("pre_rst_ov", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_ov", 64'(out_valid), 64'd0);
    check("arst_rdy", 64'(req_ready), 64'd0);
    check("arst_cnt", 64'({fwd_cnt, drop_cnt}), 64'd0);
    for (int r = 0; r < N; r++) rq[r].delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = N - 1; r >= 0; r--) gen_pkt(r, 0, 2, 200 + r);
    run_phase(0);
    end_checks();

    // Randomised traffic with bubbles and back-pressure.
    ready_mode = 1; bubbles = 1'b1;
    for (int it = 0; it < 2; it++) begin
      int sel;
      do_reset();
      for (int r = 0; r < N; r++) begin
        for (int p = 0; p < int'($urandom_range(6, 10)); p++) begin
          sel = int'($urandom_range(0, 99));
          gen_pkt(r, (sel < 70) ? 0 : ((sel < 85) ? 1 : 2),
                  int'($urandom_range(1, 6)), int'($urandom_range(1, 16383)));
        end
      end
      run_phase(0);
      end_checks();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
